// File: rtl/pm_axi_writer.sv
// Postmortem single-beat AXI4 writer.
// Re-samples the handler's level request after a settle window.
module pm_axi_writer #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [39:0] i_ddr_addr,
  input  logic [63:0] i_ddr_data,
  output logic        o_done,
  output logic [39:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        o_err,
  output logic        o_timeout,
  output logic [31:0] o_wr_cnt,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SETL = 3'd1,
    CAPT = 3'd2,
    XFER = 3'd3,
    RESP = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int SLAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int SW    = (SLAST > 0) ? $clog2(SLAST + 1) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [SW-1:0]  settle_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           aw_done;
  logic           w_done;
  logic           aw_ok;
  logic           w_ok;
  logic           settle_end;
  logic           unused_addr;

  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = 1'b1;

  assign o_state     = state;
  assign unused_addr = ^i_ddr_addr[2:0];

  assign aw_ok = aw_done |
                 (m_axi_awvalid & m_axi_awready);
  assign w_ok  = w_done |
                 (m_axi_wvalid & m_axi_wready);

  assign settle_end = (state == SETL) &&
                      (settle_cnt == SW'(SLAST));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_wr_cnt      <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            settle_cnt <= '0;
            state      <= SETL;
          end
        end
        SETL: begin
          if (settle_end) begin
            state <= CAPT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CAPT: begin
          if (!i_start) begin
            state <= IDLE;
          end else begin
            m_axi_awaddr  <= {i_ddr_addr[39:3], 3'b000};
            m_axi_wdata   <= i_ddr_data;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            state         <= XFER;
          end
        end
        XFER: begin
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            o_done       <= 1'b1;
            if (m_axi_bresp != 2'b00) begin
              o_err <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // back to SETL so the handler's next request is re-sampled
          o_wr_cnt   <= o_wr_cnt + 1'b1;
          settle_cnt <= '0;
          state      <= SETL;
        end
        default: begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // progress watchdog: flags only, the transfer keeps waiting
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
    end else if (settle_end) begin
      tmo_cnt <= '0;
    end else if (state == XFER || state == RESP) begin
      if (tmo_cnt != TW'(TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_cnt == TW'(TIMEOUT - 1)) begin
        o_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pm_axi_writer.sv
// Scoreboard bench for pm_axi_writer.
// Slave model and monitor run on the falling edge.
module tb_pm_axi_writer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [39:0] i_ddr_addr;
  logic [63:0] i_ddr_data;
  logic        o_done;
  logic [39:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        o_err;
  logic        o_timeout;
  logic [31:0] o_wr_cnt;
  logic [2:0]  o_state;

  always #5 clk = ~clk;

  pm_axi_writer #(.SETTLE(2), .TIMEOUT(1024)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_ddr_addr    (i_ddr_addr),
    .i_ddr_data    (i_ddr_data),
    .o_done        (o_done),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .o_err         (o_err),
    .o_timeout     (o_timeout),
    .o_wr_cnt      (o_wr_cnt),
    .o_state       (o_state)
  );

  typedef struct {
    logic [39:0] a;
    logic [63:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;

  int n_chk = 0;
  int n_fail = 0;

  int aw_hold = 1;
  int w_hold = 1;
  int aw_wait = 0;
  int w_wait = 0;
  int b_cnt = 0;
  int b_err_at = -1;

  int cyc = 0;
  int done_cnt = 0;
  int wr_seen = 0;
  int bphase_cnt = 0;
  int aw_hi = 0;
  int w_hi = 0;
  int aw_len_last = 0;
  int w_len_last = 0;
  int capt_cyc = 0;
  int lat_last = 0;
  int proto_err = 0;
  int xfer_cyc = 0;
  int tmo_at = -1;
  bit tmo_seen = 0;
  bit have_a = 0;
  bit have_w = 0;
  logic [39:0] got_a;
  logic [63:0] got_d;
  logic prev_done = 1'b0;
  logic prev_bready = 1'b0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!i_rst) begin
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      aw_wait = 0;
      w_wait  = 0;
      have_a  = 0;
      have_w  = 0;
      aw_hi   = 0;
      w_hi    = 0;
    end else begin
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_wait >= aw_hold - 1);
        aw_wait++;
      end else begin
        m_axi_awready = 1'b0;
        aw_wait = 0;
      end
      if (m_axi_wvalid) begin
        m_axi_wready = (w_wait >= w_hold - 1);
        w_wait++;
      end else begin
        m_axi_wready = 1'b0;
        w_wait = 0;
      end
      m_axi_bvalid = m_axi_bready;
      m_axi_bresp  = (m_axi_bready && b_cnt == b_err_at)
                     ? 2'b10 : 2'b00;

      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid) w_hi++;
      if (m_axi_awvalid && m_axi_awready) begin
        got_a = m_axi_awaddr;
        have_a = 1;
        aw_len_last = aw_hi;
        aw_hi = 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        got_d = m_axi_wdata;
        have_w = 1;
        w_len_last = w_hi;
        w_hi = 0;
      end
      if (have_a && have_w) begin
        have_a = 0;
        have_w = 0;
        wr_seen++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h, none required",
                   got_a);
        end else begin
          e = exp_q.pop_front();
          check("sb_awaddr", 64'(got_a), 64'(e.a));
          check("sb_wdata", got_d, e.d);
        end
      end
      if (m_axi_bvalid && m_axi_bready) b_cnt++;
      if (m_axi_bready && !prev_bready) bphase_cnt++;
      if (m_axi_bready && o_state != 3'd4) proto_err++;
      if (o_done && prev_done) proto_err++;
      if (o_done) begin
        done_cnt++;
        lat_last = cyc - capt_cyc;
      end
      if (o_state == 3'd2) capt_cyc = cyc;
      if (o_timeout && !tmo_seen) begin
        tmo_seen = 1;
        tmo_at = xfer_cyc;
      end
      if (o_state == 3'd3) xfer_cyc++;
      else if (o_state == 3'd2) xfer_cyc = 0;
    end
    prev_done = o_done;
    prev_bready = m_axi_bready;
  end

  task automatic wait_done(input int budget, input string nm);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (o_done) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: o_done got 0 within %0d cycles, expected 1",
               nm, budget);
    end
  endtask

  task automatic wait_state(input logic [2:0] st,
                            input int budget,
                            input string nm);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (o_state == st) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: state got %0d, expected %0d",
               nm, o_state, st);
    end
  endtask

  task automatic wait_awvalid(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (m_axi_awvalid) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_awvalid: got 0, expected 1");
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_state"}, 64'(o_state), 64'd0);
    check({p, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
    check({p, "_wvalid"}, 64'(m_axi_wvalid), 64'd0);
    check({p, "_bready"}, 64'(m_axi_bready), 64'd0);
    check({p, "_awaddr"}, 64'(m_axi_awaddr), 64'd0);
    check({p, "_wdata"}, m_axi_wdata, 64'd0);
    check({p, "_done"}, 64'(o_done), 64'd0);
    check({p, "_err"}, 64'(o_err), 64'd0);
    check({p, "_timeout"}, 64'(o_timeout), 64'd0);
    check({p, "_wr_cnt"}, 64'(o_wr_cnt), 64'd0);
    check({p, "_awlen"}, 64'(m_axi_awlen), 64'd0);
    check({p, "_awsize"}, 64'(m_axi_awsize), 64'd3);
    check({p, "_awburst"}, 64'(m_axi_awburst), 64'd1);
    check({p, "_wstrb"}, 64'(m_axi_wstrb), 64'hFF);
    check({p, "_wlast"}, 64'(m_axi_wlast), 64'd1);
  endtask

  task automatic do_reset(input string p);
    i_rst = 1'b0;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset(p);
    i_rst = 1'b1;
  endtask

  task automatic issue(input logic [39:0] a,
                       input logic [63:0] d,
                       input logic [39:0] ea);
    i_ddr_addr = a;
    i_ddr_data = d;
    exp_q.push_back('{a: ea, d: d});
    i_start = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [39:0] ba[5];
  logic [63:0] bd[5];
  int d0, w0, bp0;

  initial begin
    i_rst = 1'b0;
    i_start = 1'b0;
    i_ddr_addr = '0;
    i_ddr_data = '0;
    m_axi_awready = 1'b0;
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00;

    ba[0] = 40'h00_0010_0000; bd[0] = 64'h0123_4567_89AB_CDEF;
    ba[1] = 40'h00_0020_0008; bd[1] = 64'h1111_2222_3333_4444;
    ba[2] = 40'h00_0030_0010; bd[2] = 64'hDEAD_BEEF_0000_0002;
    ba[3] = 40'h00_0040_0018; bd[3] = 64'h5A5A_A5A5_F0F0_0F0F;
    ba[4] = 40'h00_0050_0020; bd[4] = 64'hFFFF_0000_FFFF_0004;

    do_reset("rst0");

    // handler burst of five, slave always ready
    d0 = done_cnt;
    w0 = wr_seen;
    for (int n = 0; n < 5; n++) begin
      issue(ba[n], bd[n], ba[n]);
      wait_done(40, "burst_done");
    end
    i_start = 1'b0;
    check("burst_latency", 64'(lat_last), 64'd3);
    repeat (10) @(posedge clk);
    #2;
    check("burst_state_idle", 64'(o_state), 64'd0);
    check("burst_wr_cnt", 64'(o_wr_cnt), 64'd5);
    check("burst_dones", 64'(done_cnt - d0), 64'd5);
    check("burst_writes", 64'(wr_seen - w0), 64'd5);
    check("burst_q_empty", 64'(exp_q.size()), 64'd0);
    check("burst_err", 64'(o_err), 64'd0);

    // delayed awready, inputs disturbed mid-transfer
    aw_hold = 3;
    w_hold = 1;
    d0 = done_cnt;
    w0 = wr_seen;
    bp0 = bphase_cnt;
    issue(40'h00_00AB_CDE8, 64'hFEED_FACE_CAFE_BEEF,
          40'h00_00AB_CDE8);
    wait_awvalid(20);
    i_ddr_addr = 40'hFF_FFFF_FFFF;
    i_ddr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    i_start = 1'b0;
    wait_done(20, "slow_aw_done");
    repeat (10) @(posedge clk);
    #2;
    aw_hold = 1;
    check("slow_aw_len", 64'(aw_len_last), 64'd3);
    check("slow_w_len", 64'(w_len_last), 64'd1);
    check("slow_bphases", 64'(bphase_cnt - bp0), 64'd1);
    check("slow_dones", 64'(done_cnt - d0), 64'd1);
    check("slow_writes", 64'(wr_seen - w0), 64'd1);
    check("slow_state_idle", 64'(o_state), 64'd0);
    check("slow_wr_cnt", 64'(o_wr_cnt), 64'd6);

    // error response on second of three writes
    do_reset("rst1");
    b_err_at = b_cnt + 1;
    for (int n = 0; n < 3; n++) begin
      issue(40'h00_0060_0000 + 40'(8 * n),
            64'hE000_0000_0000_0000 + 64'(n),
            40'h00_0060_0000 + 40'(8 * n));
      wait_done(40, "err_done");
      check("err_sticky", 64'(o_err), (n >= 1) ? 64'd1 : 64'd0);
    end
    i_start = 1'b0;
    b_err_at = -1;
    repeat (10) @(posedge clk);
    #2;
    check("err_wr_cnt", 64'(o_wr_cnt), 64'd3);
    check("err_final", 64'(o_err), 64'd1);
    check("err_q_empty", 64'(exp_q.size()), 64'd0);

    // unaligned request address
    issue(40'h00_0010_0005, 64'h0BAD_F00D_0000_0005,
          40'h00_0010_0000);
    wait_done(40, "align_done");
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("align_awaddr", 64'(m_axi_awaddr),
          64'h00_0010_0000);
    check("align_wr_cnt", 64'(o_wr_cnt), 64'd4);

    // awready held off well past the timeout
    aw_hold = 1101;
    tmo_seen = 0;
    check("tmo_pre", 64'(o_timeout), 64'd0);
    issue(40'h00_0080_0040, 64'h7777_6666_5555_4444,
          40'h00_0080_0040);
    wait_done(1200, "tmo_done");
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    aw_hold = 1;
    check("tmo_seen", 64'(tmo_seen), 64'd1);
    check("tmo_at_cycle", 64'(tmo_at), 64'd1024);
    check("tmo_sticky", 64'(o_timeout), 64'd1);
    check("tmo_wr_cnt", 64'(o_wr_cnt), 64'd5);
    check("tmo_q_empty", 64'(exp_q.size()), 64'd0);

    // reset while waiting on the B channel
    d0 = done_cnt;
    issue(40'h00_0090_0000, 64'h9999_0000_0000_9999,
          40'h00_0090_0000);
    wait_state(3'd4, 30, "mid_resp");
    i_rst = 1'b0;
    i_start = 1'b0;
    @(posedge clk);
    #2;
    check_reset("rst2");
    check("rst2_no_done", 64'(done_cnt - d0), 64'd0);
    @(posedge clk);
    #2;
    i_rst = 1'b1;
    issue(40'h00_0070_0038, 64'h0F0F_0F0F_1234_5678,
          40'h00_0070_0038);
    wait_done(40, "post_rst_done");
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("post_rst_wr_cnt", 64'(o_wr_cnt), 64'd1);
    check("post_rst_err", 64'(o_err), 64'd0);
    check("post_rst_q_empty", 64'(exp_q.size()), 64'd0);
    check("protocol_violations", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
